mmio_user_io_hub: RTL and testbench
===================================

MMIO_USER_IO_HUB -- requirements
Module: mmio_user_io_hub

Interface
REQ-001 SHALL have parameter LED_W, default 6, LED output width (1..32).
REQ-002 SHALL have parameter SW_W, default 2, switch input width (1..32).
REQ-003 SHALL have parameter BTN_W, default 3, button input width (1..32).
REQ-004 SHALL have parameter FIFO_DEPTH, default 32, button-event FIFO entries (power of two, >=2).
REQ-005 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  1  bus access strobe, one access per cycle.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  8  byte address; bits [1:0] ignored.
REQ-010 SHALL have port req_wdata  input  32  write data.
REQ-011 SHALL have port rd_data  output  32  registered read data.
REQ-012 SHALL have port rd_valid  output  1  high for one cycle when rd_data is valid.
REQ-013 SHALL have port inst_retire  input  1  one instruction retired this cycle.
REQ-014 SHALL have port switches  input  SW_W  asynchronous switch levels.
REQ-015 SHALL have port buttons  input  BTN_W  asynchronous button levels.
REQ-016 SHALL have port leds  output  LED_W  registered LED drive.

Function
REQ-017 Map, reads: 0x00 STATUS {fifo_full[1], fifo_empty[0]}; 0x04 FIFO_POP; 0x08 SWITCHES; 0x0C LEDS; 0x10 CYCLE; 0x14 INST; 0x1C FIFO_COUNT; zero-extended.
REQ-018 Map, writes: 0x0C LEDS <= req_wdata[LED_W-1:0]; 0x18 CNT_RST clears both counters; writes elsewhere ignored.
REQ-019 Read latency SHALL be exactly 1 cycle: access in cycle N -> rd_data and rd_valid in cycle N+1; unmapped reads return 0 with rd_valid high.
REQ-020 rd_data SHALL hold its last value while rd_valid is low.
REQ-021 switches and buttons SHALL each pass a 2-flop synchronizer before use.
REQ-022 Button event = rising-edge vector of synchronized buttons; a non-zero event vector SHALL be pushed into the FIFO the following cycle.
REQ-023 Push while full (without simultaneous pop) SHALL drop the event and leave FIFO contents unchanged.
REQ-024 Read of FIFO_POP SHALL return the head entry and pop it; on empty SHALL return 0 and not pop.
REQ-025 Simultaneous push and pop SHALL both take effect, including when full; count unchanged.
REQ-026 FIFO_COUNT SHALL report occupancy 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
REQ-027 CYCLE SHALL increment every cycle; INST SHALL increment on cycles with inst_retire=1; both wrap 0xFFFFFFFF -> 0.
REQ-028 CNT_RST write SHALL set both counters to 0 on the next edge, overriding same-cycle increment.
REQ-029 STATUS/COUNT reads SHALL reflect state before any same-cycle push/pop.

Reset
REQ-030 rst SHALL clear rd_data, rd_valid, leds, counters, FIFO pointers/count, synchronizers and edge history to 0.
REQ-031 rst asserted mid-operation SHALL discard FIFO contents and any pending read; no rd_valid in the cycle after rst.
REQ-032 Buttons held during reset SHALL NOT produce an event after reset deasserts.

Configuration
REQ-033 Macro MMIO_FIFO_OVF_EN SHALL compile in overflow tracking.
REQ-034 With MMIO_FIFO_OVF_EN: STATUS[2] sticky overflow flag, set on dropped push; 0x20 reads 16-bit saturating drop count; reading 0x20 clears flag and count.
REQ-035 Without MMIO_FIFO_OVF_EN: STATUS[2] reads 0, 0x20 reads 0, no related state exists.

Verification
REQ-036 Write 0x2A to 0x0C, read 0x0C -> leds=6'h2A, rd_data=0x2A one cycle later, rd_valid single-cycle pulse.
REQ-037 Pulse buttons=3'b010 for 4 cycles -> FIFO_COUNT=1; read 0x04 -> 0x2; next read 0x04 -> 0; STATUS=0x1.
REQ-038 Generate 33 distinct events with FIFO_DEPTH=32 -> FIFO_COUNT=32, STATUS[1]=1, 33rd dropped; with macro, 0x20 reads 1, then 0.
REQ-039 Full FIFO, event push same cycle as pop -> count stays 32, popped value is oldest entry, new event at tail.
REQ-040 Run 100 cycles with inst_retire every other cycle, write 0x18 -> CYCLE and INST read small values (<4) immediately after; force CYCLE near 0xFFFFFFFF -> wraps to 0.
REQ-041 Assert rst with 5 queued events and a read in flight -> no rd_valid after, FIFO_COUNT=0, leds=0.

Source files
------------

// File: rtl/mmio_user_io_hub.sv
// Memory-mapped user I/O hub: LEDs, synchronized switches, a button-event FIFO and cycle/instruction counters.
// Define MMIO_FIFO_OVF_EN to add a sticky overflow flag (STATUS[2]) and a drop counter at 0x20.
module mmio_user_io_hub #(
    parameter int LED_W      = 6,
    parameter int SW_W       = 2,
    parameter int BTN_W      = 3,
    parameter int FIFO_DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [7:0]       req_addr,
    input  logic [31:0]      req_wdata,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    input  logic             inst_retire,
    input  logic [SW_W-1:0]  switches,
    input  logic [BTN_W-1:0] buttons,
    output logic [LED_W-1:0] leds
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [5:0] A_STATUS = 6'h00;
    localparam logic [5:0] A_POP    = 6'h01;
    localparam logic [5:0] A_SW     = 6'h02;
    localparam logic [5:0] A_LEDS   = 6'h03;
    localparam logic [5:0] A_CYCLE  = 6'h04;
    localparam logic [5:0] A_INST   = 6'h05;
    localparam logic [5:0] A_CNTRST = 6'h06;
    localparam logic [5:0] A_COUNT  = 6'h07;
    localparam logic [5:0] A_OVF    = 6'h08;

    logic [5:0]       word;
    logic             rd_req, wr_req;
    logic [SW_W-1:0]  sw_s1, sw_s2;
    logic [BTN_W-1:0] btn_s1, btn_s2, btn_prev, btn_edge, evt_q;
    logic [1:0]       arm_cnt;
    logic [BTN_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty, fifo_full, push, pop, drop;
    logic [31:0]      cycle_cnt, inst_cnt;
    logic             cnt_rst;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    assign word        = req_addr[7:2];
    assign rd_req      = req_valid && !req_we;
    assign wr_req      = req_valid && req_we;
    assign unused_bits = ^{req_addr[1:0], req_wdata};

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);
    assign btn_edge   = btn_s2 & ~btn_prev;
    assign pop        = rd_req && (word == A_POP) && !fifo_empty;
    assign push       = (|evt_q) && (!fifo_full || pop);
    assign drop       = (|evt_q) && fifo_full && !pop;
    assign cnt_rst    = wr_req && (word == A_CNTRST);

`ifdef MMIO_FIFO_OVF_EN
    logic        ovf_flag;
    logic [15:0] drop_cnt;
    logic        ovf_clr;

    assign ovf_clr = rd_req && (word == A_OVF);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_flag <= 1'b0;
            drop_cnt <= '0;
        end else if (ovf_clr) begin
            ovf_flag <= drop;
            drop_cnt <= {15'd0, drop};
        end else if (drop) begin
            ovf_flag <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

    // Synchronizers; events are masked until the pipeline has seen post-reset
    // levels so a button held through reset does not look like a new press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1    <= '0;
            sw_s2    <= '0;
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
            evt_q    <= '0;
            arm_cnt  <= '0;
        end else begin
            sw_s1    <= switches;
            sw_s2    <= sw_s1;
            btn_s1   <= buttons;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
            if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
            evt_q    <= (arm_cnt == 2'd3) ? btn_edge : '0;
        end
    end

    // Storage has no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= evt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else if (cnt_rst) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (inst_retire) inst_cnt <= inst_cnt + 32'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (word)
`ifdef MMIO_FIFO_OVF_EN
            A_STATUS: rd_mux = {29'd0, ovf_flag, fifo_full, fifo_empty};
            A_OVF:    rd_mux = {16'd0, drop_cnt};
`else
            A_STATUS: rd_mux = {30'd0, fifo_full, fifo_empty};
`endif
            A_POP:    rd_mux = fifo_empty ? 32'd0 : 32'(mem[rd_ptr]);
            A_SW:     rd_mux = 32'(sw_s2);
            A_LEDS:   rd_mux = 32'(leds);
            A_CYCLE:  rd_mux = cycle_cnt;
            A_INST:   rd_mux = inst_cnt;
            A_COUNT:  rd_mux = 32'(count);
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            leds     <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) rd_data <= rd_mux;
            if (wr_req && (word == A_LEDS)) leds <= req_wdata[LED_W-1:0];
        end
    end

endmodule

// File: tb/tb_mmio_user_io_hub.sv
// Self-checking bench for mmio_user_io_hub: vector table, randomized traffic against a queue model, corner sequences.
module tb_mmio_user_io_hub;

    localparam int LED_W      = 6;
    localparam int SW_W       = 2;
    localparam int BTN_W      = 3;
    localparam int FIFO_DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_we = 1'b0;
    logic [7:0]       req_addr = '0;
    logic [31:0]      req_wdata = '0;
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic             inst_retire = 1'b0;
    logic [SW_W-1:0]  switches = '0;
    logic [BTN_W-1:0] buttons = '0;
    logic [LED_W-1:0] leds;

    mmio_user_io_hub #(
        .LED_W(LED_W), .SW_W(SW_W), .BTN_W(BTN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rd_data(rd_data),
        .rd_valid(rd_valid), .inst_retire(inst_retire), .switches(switches),
        .buttons(buttons), .leds(leds)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int drops = 0;
    logic [BTN_W-1:0] q[$];
    logic [LED_W-1:0] leds_m = '0;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        @(negedge clk);
        d = rd_data; v = rd_valid;
        req_valid = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        v;
        bus_read(a, d, v);
        check(name, d, exp);
        check({name, " valid"}, {31'd0, v}, 32'd1);
    endtask

    // Press a button pattern long enough to pass the synchronizer, then release.
    task automatic pulse_btn(input logic [BTN_W-1:0] v);
        @(negedge clk);
        buttons = v;
        repeat (4) @(negedge clk);
        buttons = '0;
        repeat (5) @(negedge clk);
        if (q.size() < FIFO_DEPTH) q.push_back(v);
        else drops++;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        v;
        logic [BTN_W-1:0] bv;
        logic [SW_W-1:0]  sw;
        logic [7:0]       ua;
        int               op;

        tbl[0]  = '{1'b0, 8'h00, 32'h0,        32'h1};
        tbl[1]  = '{1'b0, 8'h1C, 32'h0,        32'h0};
        tbl[2]  = '{1'b0, 8'h04, 32'h0,        32'h0};
        tbl[3]  = '{1'b1, 8'h0C, 32'hFFFFFF15, 32'h15};
        tbl[4]  = '{1'b0, 8'h0C, 32'h0,        32'h15};
        tbl[5]  = '{1'b0, 8'h0E, 32'h0,        32'h15};
        tbl[6]  = '{1'b1, 8'h30, 32'h3F,       32'h15};
        tbl[7]  = '{1'b0, 8'h0C, 32'h0,        32'h15};
        tbl[8]  = '{1'b0, 8'h08, 32'h0,        32'h2};
        tbl[9]  = '{1'b0, 8'h24, 32'h0,        32'h0};
        tbl[10] = '{1'b0, 8'h20, 32'h0,        32'h0};
        tbl[11] = '{1'b0, 8'h18, 32'h0,        32'h0};

        switches = 2'b10;
        idle(4);
        rst = 1'b0;
        check("reset rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset rd_data", rd_data, 32'd0);
        check("reset leds", 32'(leds), 32'd0);
        idle(3);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].we) begin
                bus_write(tbl[i].addr, tbl[i].wdata);
                check($sformatf("tbl[%0d] leds", i), 32'(leds), tbl[i].exp);
            end else begin
                read_check($sformatf("tbl[%0d] rd", i), tbl[i].addr, tbl[i].exp);
            end
        end

        // LED write then single-cycle read pulse with held data
        bus_write(8'h0C, 32'h2A);
        leds_m = 6'h2A;
        check("led write", 32'(leds), 32'h2A);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h0C;
        @(negedge clk);
        req_valid = 1'b0;
        check("led rd data", rd_data, 32'h2A);
        check("led rd valid", {31'd0, rd_valid}, 32'd1);
        @(negedge clk);
        check("led rd valid drop", {31'd0, rd_valid}, 32'd0);
        check("led rd data hold", rd_data, 32'h2A);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    d = $urandom;
                    bus_write(8'h0C | 8'($urandom_range(0, 3)), d);
                    leds_m = d[LED_W-1:0];
                    check("rand led write", 32'(leds), 32'(leds_m));
                end
                1: read_check("rand led read", 8'h0C, 32'(leds_m));
                2: begin
                    sw = SW_W'($urandom_range(0, 3));
                    switches = sw;
                    idle(3);
                    read_check("rand switches", 8'h08, 32'(sw));
                end
                default: begin
                    ua = 8'($urandom_range(9, 63) * 4 + $urandom_range(0, 3));
                    bus_write(ua, $urandom);
                    check("rand unmapped write", 32'(leds), 32'(leds_m));
                    read_check("rand unmapped read", ua, 32'd0);
                end
            endcase
        end

        for (int i = 0; i < 10; i++) pulse_btn(BTN_W'($urandom_range(1, 7)));
        read_check("rand fifo count", 8'h1C, 32'(q.size()));
        for (int i = 0; i < 10; i++) begin
            bv = q.pop_front();
            read_check("rand fifo pop", 8'h04, 32'(bv));
        end
        read_check("rand status empty", 8'h00, 32'h1);

        pulse_btn(3'b010);
        read_check("single count", 8'h1C, 32'd1);
        void'(q.pop_front());
        read_check("single pop", 8'h04, 32'h2);
        read_check("empty pop", 8'h04, 32'h0);
        read_check("single status", 8'h00, 32'h1);

        for (int i = 0; i < 33; i++) pulse_btn(BTN_W'((i % 7) + 1));
        read_check("full count", 8'h1C, 32'd32);
`ifdef MMIO_FIFO_OVF_EN
        read_check("full status", 8'h00, 32'h6);
        read_check("ovf count", 8'h20, 32'(drops));
        read_check("ovf cleared", 8'h20, 32'd0);
`endif
        read_check("full status", 8'h00, 32'h2);

        // New event reaches the FIFO on the same edge that a pop is issued
        bv = 3'b100;
        @(negedge clk);
        buttons = bv;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h04;
        @(negedge clk);
        req_valid = 1'b0;
        buttons = '0;
        check("full push+pop data", rd_data, 32'(q.pop_front()));
        q.push_back(bv);
        idle(5);
        read_check("full push+pop count", 8'h1C, 32'd32);
        for (int i = 0; i < 32; i++) read_check("drain pop", 8'h04, 32'(q.pop_front()));
        read_check("drained status", 8'h00, 32'h1);

        bus_write(8'h18, 32'h0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            inst_retire = (i % 2) == 1;
        end
        @(negedge clk);
        inst_retire = 1'b0;
        read_check("inst count", 8'h14, 32'd50);
        bus_read(8'h10, d, v);
        check("cycle count >= 100", {31'd0, d >= 32'd100}, 32'd1);
        bus_write(8'h18, 32'h0);
        bus_read(8'h10, d, v);
        check("cycle after clear small", {31'd0, d < 32'd4}, 32'd1);
        read_check("inst after clear", 8'h14, 32'd0);

        @(negedge clk);
        force dut.cycle_cnt = 32'hFFFFFFFE;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
        #1 release dut.cycle_cnt;
        @(negedge clk);
        check("cycle pre-wrap", rd_data, 32'hFFFFFFFE);
        @(negedge clk);
        check("cycle max", rd_data, 32'hFFFFFFFF);
        @(negedge clk);
        check("cycle wrap", rd_data, 32'h0);
        req_valid = 1'b0;

        bus_write(8'h0C, 32'h3C);
        for (int i = 0; i < 5; i++) pulse_btn(BTN_W'(i + 1));
        read_check("pre-reset count", 8'h1C, 32'd5);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h0C;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        check("mid reset rd_valid", {31'd0, rd_valid}, 32'd0);
        check("mid reset leds", 32'(leds), 32'd0);
        @(negedge clk);
        check("post reset rd_valid", {31'd0, rd_valid}, 32'd0);
        q.delete();
        leds_m = '0;
        read_check("post reset count", 8'h1C, 32'd0);
        read_check("post reset status", 8'h00, 32'h1);

        @(negedge clk);
        rst = 1'b1;
        buttons = 3'b101;
        idle(3);
        rst = 1'b0;
        idle(10);
        read_check("held button count", 8'h1C, 32'd0);
        buttons = '0;
        idle(6);
        read_check("released button count", 8'h1C, 32'd0);
        pulse_btn(3'b001);
        read_check("after reset press count", 8'h1C, 32'd1);
        read_check("after reset press pop", 8'h04, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
